// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster timing, sync/display-enable generation and VRAM fetch addressing.
// Optional macro VGA_FETCH_ALIGN_EN delays hsync/vsync/de by two pixel clocks to match fetch latency.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        plane,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic [3:0]  glyph_row,
  output logic [2:0]  glyph_col,
  output logic [16:0] vram_addr,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] MODE_TEXT = 2'b00;
  localparam logic [1:0] MODE_MONO = 2'b01;
  localparam logic [1:0] MODE_4BPP = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [16:0] TEXT_PAGE = 17'h01000;
  localparam logic [16:0] BMP_PAGE  = 17'h09600;

  logic [9:0]  hCount_q, hCount_d;
  logic [9:0]  vCount_q, vCount_d;
  logic [1:0]  mode_q, mode_d;
  logic        plane_q, plane_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [16:0] addr_q, addr_d;
  logic        lineStart_q, lineStart_d;
  logic        frameStart_q, frameStart_d;
  logic        wrapH;
  logic        frameWrap;
  logic [16:0] hDiv8, hDiv4, vDiv16, vFull, vDiv2;

  // Mode/plane are captured only at the frame wrap so a frame never tears.
  always_comb begin
    wrapH     = (hCount_q == H_LAST);
    hCount_d  = wrapH ? '0 : hCount_q + 10'd1;
    vCount_d  = vCount_q;
    if (wrapH) begin
      vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 10'd1;
    end
    frameWrap = (hCount_d == '0) && (vCount_d == '0);
    mode_d    = frameWrap ? mode : mode_q;
    plane_d   = frameWrap ? plane : plane_q;
  end

  // Decode uses next-state counters so registered outputs line up with hcount/vcount.
  always_comb begin
    hDiv8   = {10'd0, hCount_d[9:3]};
    hDiv4   = {9'd0, hCount_d[9:2]};
    vDiv16  = {11'd0, vCount_d[9:4]};
    vFull   = {7'd0, vCount_d};
    vDiv2   = {8'd0, vCount_d[9:1]};
    hsync_d = !((hCount_d >= H_SYNC_START) && (hCount_d < H_SYNC_END));
    vsync_d = !((vCount_d >= V_SYNC_START) && (vCount_d < V_SYNC_END));
    de_d    = (hCount_d < H_ACT) && (vCount_d < V_ACT) && (mode_d != MODE_RSVD);
    addr_d  = '0;
    if (de_d) begin
      case (mode_d)
        MODE_TEXT: addr_d = (vDiv16 << 6) + (vDiv16 << 4) + hDiv8 + (plane_d ? TEXT_PAGE : 17'd0);
        MODE_MONO: addr_d = (vFull << 6) + (vFull << 4) + hDiv8 + (plane_d ? BMP_PAGE : 17'd0);
        MODE_4BPP: addr_d = (vDiv2 << 7) + (vDiv2 << 5) + hDiv4 + (plane_d ? BMP_PAGE : 17'd0);
        default:   addr_d = '0;
      endcase
    end
    lineStart_d  = (hCount_d == '0);
    frameStart_d = frameWrap;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hCount_q     <= H_LAST;
      vCount_q     <= V_LAST;
      mode_q       <= MODE_TEXT;
      plane_q      <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      addr_q       <= '0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      mode_q       <= mode_d;
      plane_q      <= plane_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      addr_q       <= addr_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

`ifdef VGA_FETCH_ALIGN_EN
  logic [1:0] hsyncPipe_q, vsyncPipe_q, dePipe_q;

  // Two extra stages cover the VRAM read plus font-ROM lookup.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hsyncPipe_q <= 2'b11;
      vsyncPipe_q <= 2'b11;
      dePipe_q    <= 2'b00;
    end else begin
      hsyncPipe_q <= {hsyncPipe_q[0], hsync_q};
      vsyncPipe_q <= {vsyncPipe_q[0], vsync_q};
      dePipe_q    <= {dePipe_q[0], de_q};
    end
  end

  assign hsync = hsyncPipe_q[1];
  assign vsync = vsyncPipe_q[1];
  assign de    = dePipe_q[1];
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
`endif

  assign hcount      = hCount_q;
  assign vcount      = vCount_q;
  assign glyph_row   = vCount_q[3:0];
  assign glyph_col   = hCount_q[2:0];
  assign vram_addr   = addr_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Video-side counterpart of the CPU-facing VGA register block: generates the 640x480 raster timing, and drives the hsync and vsync that the register block reports in its status byte.
Consumes the mode and plane settings that the register block exports, and produces the VRAM fetch address for the current pixel.
Also provides display-enable and frame/line strobes to the pixel pipeline and the interrupt logic.
Runs entirely on the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
pclk  input  1  pixel clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
mode  input  2  video mode: 00 text, 01 mono bitmap, 10 4bpp bitmap, 11 reserved
plane  input  1  selects display page
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
de  output  1  display enable, high in the visible area
hcount  output  10  current pixel column, 0..H_TOTAL-1
vcount  output  10  current line, 0..V_TOTAL-1
glyph_row  output  4  text scanline within a character cell, vcount[3:0]
glyph_col  output  3  pixel within a character cell, hcount[2:0]
vram_addr  output  17  VRAM byte address for the current pixel
line_start  output  1  one-cycle pulse at hcount==0
frame_start  output  1  one-cycle pulse at hcount==0 && vcount==0

Behaviour:
- Derived totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Counters:
  - hcount increments every pclk and wraps from H_TOTAL-1 to 0.
  - vcount increments only on an hcount wrap, and wraps from V_TOTAL-1 to 0.
- Output registration and alignment:
  - All outputs are registered.
  - Decode is taken from the next counter value, so every output is consistent with the hcount/vcount presented in the same cycle (zero relative skew).
- Reset values (reset sampled high):
  - hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - hsync=1, vsync=1, de=0, vram_addr=0, line_start=0, frame_start=0.
  - Latched mode=00, latched plane=0.
  - First edge with reset low: counters go to (0,0); de=1, line_start=1, frame_start=1.
  - Reset asserted mid-frame: the same values load on the next edge; the partial frame is abandoned.
- hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- de=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE and the latched mode != 11.
- Mode/plane latching:
  - mode and plane are latched only on the cycle frame_start asserts (counter wrap to 0,0).
  - Changes mid-frame take effect from the next frame; no tearing.
- vram_addr, computed from the latched mode and plane:
  - 00 text (80x30 cells, 8x16 glyph): (vcount>>4)*80 + (hcount>>3) + plane*0x01000. Range 0..2399 per page.
  - 01 mono 640x480, 8 px/byte: vcount*80 + (hcount>>3) + plane*0x09600.
  - 10 4bpp 320x240, pixel-doubled, 2 px/byte: (vcount>>1)*160 + (hcount>>2) + plane*0x09600.
  - 11 reserved: de=0 for the whole frame; vram_addr=0; hsync and vsync timing unchanged.
  - When de=0: vram_addr=0.
- Multiplies are by constants only; the implementation uses shift-add. All arithmetic is 17-bit unsigned, and results never exceed 0x12BFF.
- glyph_row and glyph_col are plain counter slices, valid in all modes; they are used only in text mode.

Optional Feature:
Macro: VGA_FETCH_ALIGN_EN.
- Defined: hsync, vsync and de are delayed by a 2-stage shift register, matching the VRAM-read plus font-ROM latency.
  - vram_addr, hcount, vcount, glyph_row, glyph_col, line_start and frame_start are not delayed.
  - Reset clears both stages to hsync=1, vsync=1, de=0.
- Undefined: no delay; all outputs are aligned as described above.

Test Plan:
- Reset 3 cycles, then release -> first cycle after release: hcount=0, vcount=0, de=1, frame_start=1; previous cycle hsync=1, vsync=1, de=0.
- Free-run one line -> hsync low exactly for hcount 656..751 (96 cycles); de low from hcount 640; line_start once per 800 cycles.
- Free-run a full frame -> vsync low for vcount 490..491 (1600 cycles); frame_start period 420000 cycles.
- mode=00, plane=1:
  - (hcount=17, vcount=35) -> vram_addr = 2*80 + 2 + 0x1000 = 0x010A2; glyph_row=3, glyph_col=1.
  - (hcount=700) -> vram_addr=0, de=0.
- Mode switch:
  - Mode 10 set at vcount=100 -> mode 00 addressing continues to the end of the frame.
  - Next frame, at hcount=9, vcount=5 -> vram_addr = 2*160 + 2 = 322.
  - Mode 11 -> de=0 for the whole frame while syncs continue.
- With VGA_FETCH_ALIGN_EN -> hsync falls at hcount=658 and de falls at hcount=642; vram_addr is unchanged from the undelayed build.
